// File: rtl/ssa_hw_pkg.sv
// Shared definitions for the parallel-copy lowering hardware.
// Holds the register-index width, copy-table depth, the scratch register
// used to break copy cycles, the copy record and the sequencer state enum.
package ssa_hw_pkg;

  localparam int REG_W      = 5;
  localparam int MAX_COPIES = 8;
  localparam int IDX_W      = $clog2(MAX_COPIES);
  localparam int CNT_W      = $clog2(MAX_COPIES + 1);

  // Highest register index is reserved as scratch for cycle breaking.
  localparam logic [REG_W-1:0] TMP_REG = {REG_W{1'b1}};

  typedef struct packed {
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] src;
  } copy_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } pcs_state_e;

endpackage

// File: rtl/pcs_select.sv
// Combinational move selection over the copy table.
// Ports:
//   pending      in  per-entry pending bits
//   copies       in  copy table {dst, src}
//   ready_mask   out pending entries whose dst is not read by another pending entry
//   sel_idx      out lowest-index ready entry (0 when none)
//   brk_idx      out lowest-index pending entry, the cycle-break victim
//   rewrite_mask out pending entries whose src equals dst of the break victim
module pcs_select
  import ssa_hw_pkg::*;
(
  input  logic [MAX_COPIES-1:0]  pending,
  input  copy_t [MAX_COPIES-1:0] copies,
  output logic [MAX_COPIES-1:0]  ready_mask,
  output logic [IDX_W-1:0]       sel_idx,
  output logic [IDX_W-1:0]       brk_idx,
  output logic [MAX_COPIES-1:0]  rewrite_mask
);

  // An entry may be written once no other pending copy still needs to read
  // its destination.
  always_comb begin
    ready_mask = '0;
    for (int i = 0; i < MAX_COPIES; i++) begin
      ready_mask[i] = pending[i];
      for (int j = 0; j < MAX_COPIES; j++) begin
        if (j != i && pending[j] && (copies[j].src == copies[i].dst)) begin
          ready_mask[i] = 1'b0;
        end
      end
    end
  end

  // Descending scan so the lowest index wins.
  always_comb begin
    sel_idx = '0;
    brk_idx = '0;
    for (int i = MAX_COPIES - 1; i >= 0; i--) begin
      if (ready_mask[i]) sel_idx = IDX_W'(i);
      if (pending[i])    brk_idx = IDX_W'(i);
    end
  end

  always_comb begin
    rewrite_mask = '0;
    for (int j = 0; j < MAX_COPIES; j++) begin
      rewrite_mask[j] = pending[j] && (copies[j].src == copies[brk_idx].dst);
    end
  end

endmodule

// File: rtl/parallel_copy_sequencer.sv
// Sequentializes one batch of parallel register copies into ordered moves,
// breaking copy cycles through TMP_REG.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   copy beat handshake; in_dst, in_src, in_last payload
//   out_valid/out_ready move handshake; out_dst, out_src, out_last payload
//   done                one-cycle pulse once the batch is fully emitted
//   err                 sticky batch error, cleared by the next batch's first beat
//   dbg_state           current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. A producer holding valid keeps its payload stable until the transfer;
// out_* are registered and hold while out_valid && !out_ready.
module parallel_copy_sequencer
  import ssa_hw_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REG_W-1:0] in_dst,
  input  logic [REG_W-1:0] in_src,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REG_W-1:0] out_dst,
  output logic [REG_W-1:0] out_src,
  output logic             out_last,
  output logic             done,
  output logic             err,
  output pcs_state_e       dbg_state
);

  pcs_state_e             state, state_d;
  copy_t [MAX_COPIES-1:0] copies;
  logic [MAX_COPIES-1:0]  pending;
  logic [CNT_W-1:0]       count;
  logic                   arm;         // first EMIT cycle, lets the table settle
  logic                   first_beat;  // next handshake opens a new batch

  logic [MAX_COPIES-1:0]  ready_mask, rewrite_mask, dst_hit, rest_mask;
  logic [IDX_W-1:0]       sel_idx, brk_idx;
  logic                   any_ready, any_pending;
  logic                   hs_in, slot_free, beat_tmp, beat_self, beat_dup;
  logic                   beat_wr, beat_err, overflow;
  logic                   do_emit, do_ready, do_break;

  pcs_select u_select (
    .pending      (pending),
    .copies       (copies),
    .ready_mask   (ready_mask),
    .sel_idx      (sel_idx),
    .brk_idx      (brk_idx),
    .rewrite_mask (rewrite_mask)
  );

  assign dbg_state   = state;
  assign any_ready   = |ready_mask;
  assign any_pending = |pending;
  assign rest_mask   = pending & ~(MAX_COPIES'(1) << sel_idx);

  always_comb begin
    dst_hit = '0;
    for (int i = 0; i < MAX_COPIES; i++) begin
      dst_hit[i] = pending[i] && (copies[i].dst == in_dst);
    end
  end

  // Next state and per-cycle control decisions.
  always_comb begin
    state_d   = state;
    hs_in     = in_valid && in_ready && (state == LOAD);
    slot_free = !out_valid || out_ready;
    beat_tmp  = (in_dst == TMP_REG) || (in_src == TMP_REG);
    beat_self = (in_dst == in_src);
    beat_dup  = |dst_hit;
    beat_err  = hs_in && (beat_tmp || (!beat_self && beat_dup));
    beat_wr   = hs_in && !beat_tmp && !beat_self && !beat_dup;
    // Filling the last slot without in_last closes the batch as an error.
    overflow  = beat_wr && !in_last && (count == CNT_W'(MAX_COPIES - 1));
    do_emit   = (state == EMIT) && !arm && slot_free;
    do_ready  = do_emit && any_ready;
    do_break  = do_emit && !any_ready && any_pending;

    case (state)
      LOAD:    if (hs_in && (in_last || overflow)) state_d = EMIT;
      EMIT:    if (do_emit && !any_pending) state_d = DONE;
      DONE:    state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      copies     <= '0;
      pending    <= '0;
      count      <= '0;
      arm        <= 1'b0;
      first_beat <= 1'b1;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_dst    <= '0;
      out_src    <= '0;
      out_last   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      in_ready <= (state_d == LOAD);
      done     <= (state_d == DONE);
      arm      <= (state == LOAD) && (state_d == EMIT);

      if (hs_in) first_beat <= 1'b0;
      // Setting wins over the new-batch clear so a bad first beat still flags.
      if (hs_in && first_beat)   err <= 1'b0;
      if (beat_err || overflow)  err <= 1'b1;

      if (beat_wr) begin
        copies[count[IDX_W-1:0]]  <= {in_dst, in_src};
        pending[count[IDX_W-1:0]] <= 1'b1;
        count                     <= count + CNT_W'(1);
      end

      if (do_ready) begin
        out_valid        <= 1'b1;
        out_dst          <= copies[sel_idx].dst;
        out_src          <= copies[sel_idx].src;
        out_last         <= (rest_mask == '0);
        pending[sel_idx] <= 1'b0;
      end else if (do_break) begin
        // Save the victim's destination to scratch and redirect its readers;
        // the victim itself becomes ready on the next selection.
        out_valid <= 1'b1;
        out_dst   <= TMP_REG;
        out_src   <= copies[brk_idx].dst;
        out_last  <= 1'b0;
        for (int j = 0; j < MAX_COPIES; j++) begin
          if (rewrite_mask[j]) copies[j].src <= TMP_REG;
        end
      end else if (do_emit) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      if (state == DONE) begin
        pending    <= '0;
        count      <= '0;
        first_beat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_parallel_copy_sequencer.sv
// Testbench for parallel_copy_sequencer: directed vector table, hand-written
// timing/backpressure/reset sequences, and random batches checked against a
// queue-based reference model plus a register-file semantic check.
module tb_parallel_copy_sequencer;
  import ssa_hw_pkg::*;

  localparam int MW = 2 * REG_W + 1;   // {dst, src, last}
  localparam logic [9:0] NC = '0;

  logic             clk, rst_n;
  logic             in_valid, in_ready, in_last;
  logic [REG_W-1:0] in_dst, in_src;
  logic             out_valid, out_ready, out_last, done, err;
  logic [REG_W-1:0] out_dst, out_src;
  pcs_state_e       dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [MW-1:0]    got_q[$];
  logic [MW-1:0]    exp_q[$];
  logic [REG_W-1:0] bq_d[$], bq_s[$], acc_d[$], acc_s[$];

  parallel_copy_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dst    (in_dst),
    .in_src    (in_src),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dst   (out_dst),
    .out_src   (out_src),
    .out_last  (out_last),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: got timeout, want finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [MW-1:0] prev_out;
  logic          prev_stall, prev_last_hs;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      if (prev_stall)   check("stall_hold", {out_valid, out_dst, out_src, out_last}, {1'b1, prev_out});
      if (prev_last_hs) check("done_after_last", done, 1);
      if (out_valid && out_ready) got_q.push_back({out_dst, out_src, out_last});
      prev_stall   = out_valid && !out_ready;
      prev_out     = {out_dst, out_src, out_last};
      prev_last_hs = out_valid && out_ready && out_last;
    end
  end

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [REG_W-1:0] d, input logic [REG_W-1:0] s, input logic l);
    int t = 0;
    in_valid = 1'b1;
    in_dst   = d;
    in_src   = s;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("beat_accepted", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_all(input logic last_on_final);
    got_q.delete();
    for (int i = 0; i < bq_d.size(); i++) begin
      send_beat(bq_d[i], bq_s[i], last_on_final && (i == bq_d.size() - 1));
    end
  endtask

  // mode 0: out_ready held high, 1: toggled 1/0, 2: random
  task automatic wait_done(input int mode, input logic exp_err);
    int   t    = 0;
    logic seen = 1'b0;
    while (!seen && t < 400) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (t % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        t++;
      end
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("err_at_done", err, exp_err);
      check("state_in_done", 32'(dbg_state), 32'(DONE));
      check("in_ready_in_done", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    check("done_one_cycle", done, 0);
    check("in_ready_after_done", in_ready, 1);
  endtask

  // ---------------- reference model ----------------
  // Filters the beats by the batch rules, then repeatedly emits the earliest
  // remaining copy whose destination nobody else still reads; if there is
  // none, saves the earliest copy's destination to scratch.
  task automatic model(input logic last_on_final, output logic merr);
    logic [REG_W-1:0] td[$], ts[$];
    int   pick;
    logic dup, is_last, read_by_other;
    merr = 1'b0;
    exp_q.delete();
    for (int i = 0; i < bq_d.size(); i++) begin
      is_last = last_on_final && (i == bq_d.size() - 1);
      dup = 1'b0;
      foreach (td[k]) if (td[k] == bq_d[i]) dup = 1'b1;
      if (bq_d[i] == TMP_REG || bq_s[i] == TMP_REG) merr = 1'b1;
      else if (bq_d[i] == bq_s[i]) begin end
      else if (dup) merr = 1'b1;
      else begin
        td.push_back(bq_d[i]);
        ts.push_back(bq_s[i]);
        if (td.size() == MAX_COPIES && !is_last) begin
          merr = 1'b1;
          break;
        end
      end
    end
    acc_d = td;
    acc_s = ts;
    while (td.size() > 0) begin
      pick = -1;
      for (int i = 0; i < td.size() && pick < 0; i++) begin
        read_by_other = 1'b0;
        for (int j = 0; j < ts.size(); j++) if (j != i && ts[j] == td[i]) read_by_other = 1'b1;
        if (!read_by_other) pick = i;
      end
      if (pick >= 0) begin
        exp_q.push_back({td[pick], ts[pick], td.size() == 1});
        td.delete(pick);
        ts.delete(pick);
      end else begin
        exp_q.push_back({TMP_REG, td[0], 1'b0});
        for (int j = 0; j < ts.size(); j++) if (ts[j] == td[0]) ts[j] = TMP_REG;
      end
    end
  endtask

  // Sequential moves must leave every architectural register holding what
  // the parallel copy would have produced.
  task automatic semantic_check();
    int regs[32], par[32];
    int bad = 0;
    for (int r = 0; r < 32; r++) begin
      regs[r] = r * 3 + 100;
      par[r]  = regs[r];
    end
    foreach (acc_d[i]) par[acc_d[i]] = regs[acc_s[i]];
    foreach (got_q[i]) regs[got_q[i][MW-1 -: REG_W]] = regs[got_q[i][REG_W:1]];
    for (int r = 0; r < 31; r++) if (regs[r] != par[r]) bad++;
    check("parallel_semantics", bad, 0);
  endtask

  task automatic compare_moves(input string tag);
    check({tag, "_move_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_move"}, got_q[i], exp_q[i]);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [2:0]      n_beats;
    logic [3:0][9:0] beats;   // {dst, src}
    logic [2:0]      n_moves;
    logic [4:0][9:0] moves;   // {dst, src}
    logic            exp_err;
  } vec_t;

  function automatic vec_t mk(input int nb, input logic [9:0] b0, b1, b2, b3,
                              input int nm, input logic [9:0] m0, m1, m2, m3, m4,
                              input logic e);
    vec_t v;
    v.n_beats = 3'(nb);
    v.beats   = {b3, b2, b1, b0};
    v.n_moves = 3'(nm);
    v.moves   = {m4, m3, m2, m1, m0};
    v.exp_err = e;
    return v;
  endfunction

  vec_t vecs[8];

  // ---------------- test sequence ----------------
  initial begin
    logic merr;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_dst    = '0;
    in_src    = '0;
    out_ready = 1'b1;

    vecs[0] = mk(2, {5'd1, 5'd2}, {5'd3, 5'd4}, NC, NC, 2, {5'd1, 5'd2}, {5'd3, 5'd4}, NC, NC, NC, 1'b0);
    vecs[1] = mk(2, {5'd2, 5'd3}, {5'd1, 5'd2}, NC, NC, 2, {5'd1, 5'd2}, {5'd2, 5'd3}, NC, NC, NC, 1'b0);
    vecs[2] = mk(2, {5'd1, 5'd2}, {5'd2, 5'd1}, NC, NC, 3, {5'd31, 5'd1}, {5'd1, 5'd2}, {5'd2, 5'd31}, NC, NC, 1'b0);
    vecs[3] = mk(3, {5'd1, 5'd2}, {5'd2, 5'd3}, {5'd3, 5'd1}, NC, 4, {5'd31, 5'd1}, {5'd1, 5'd2}, {5'd2, 5'd3}, {5'd3, 5'd31}, NC, 1'b0);
    vecs[4] = mk(3, {5'd5, 5'd5}, {5'd6, 5'd7}, {5'd6, 5'd8}, NC, 1, {5'd6, 5'd7}, NC, NC, NC, NC, 1'b1);
    vecs[5] = mk(1, {5'd4, 5'd4}, NC, NC, NC, 0, NC, NC, NC, NC, NC, 1'b0);
    vecs[6] = mk(2, {5'd31, 5'd3}, {5'd4, 5'd5}, NC, NC, 1, {5'd4, 5'd5}, NC, NC, NC, NC, 1'b1);
    vecs[7] = mk(2, {5'd2, 5'd1}, {5'd3, 5'd1}, NC, NC, 2, {5'd2, 5'd1}, {5'd3, 5'd1}, NC, NC, NC, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_dst", out_dst, 0);
    check("rst_out_src", out_src, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_state", 32'(dbg_state), 32'(LOAD));
    rst_n = 1'b1;

    // Directed vectors; the swap runs under toggling out_ready.
    for (int v = 0; v < 8; v++) begin
      bq_d.delete();
      bq_s.delete();
      exp_q.delete();
      for (int i = 0; i < vecs[v].n_beats; i++) begin
        bq_d.push_back(vecs[v].beats[i][9:5]);
        bq_s.push_back(vecs[v].beats[i][4:0]);
      end
      for (int i = 0; i < vecs[v].n_moves; i++) begin
        exp_q.push_back({vecs[v].moves[i], i == vecs[v].n_moves - 1});
      end
      send_all(1'b1);
      wait_done((v == 2) ? 1 : 0, vecs[v].exp_err);
      compare_moves("vec");
    end

    // Latency and throughput on two independent copies.
    bq_d = '{5'd1, 5'd3};
    bq_s = '{5'd2, 5'd4};
    model(1'b1, merr);
    out_ready = 1'b1;
    send_all(1'b1);
    @(negedge clk);
    check("lat_cycle0_valid", out_valid, 0);
    check("lat_in_ready_low", in_ready, 0);
    @(negedge clk);
    check("lat_cycle1_valid", out_valid, 0);
    @(negedge clk);
    check("lat_cycle2_valid", out_valid, 1);
    check("lat_first_dst", out_dst, 1);
    @(negedge clk);
    check("thru_second_valid", out_valid, 1);
    check("thru_second_dst", out_dst, 3);
    check("thru_second_last", out_last, 1);
    @(negedge clk);
    check("lat_done", done, 1);
    check("lat_done_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    check("lat_done_pulse", done, 0);
    compare_moves("lat");

    // Table fills without in_last.
    bq_d.delete();
    bq_s.delete();
    for (int i = 0; i < MAX_COPIES; i++) begin
      bq_d.push_back(REG_W'(i + 1));
      bq_s.push_back(REG_W'(i + 11));
    end
    model(1'b0, merr);
    check("ovf_model_err", merr, 1);
    send_all(1'b0);
    wait_done(0, merr);
    compare_moves("ovf");

    // Reset while a stalled move is being offered.
    bq_d = '{5'd1, 5'd2, 5'd3};
    bq_s = '{5'd2, 5'd3, 5'd1};
    out_ready = 1'b0;
    send_all(1'b1);
    for (int t = 0; t < 10 && !out_valid; t++) @(negedge clk);
    check("mid_emit_valid", out_valid, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_dst", out_dst, 0);
    check("mid_rst_out_src", out_src, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    got_q.delete();
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_no_moves", got_q.size(), 0);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);
    bq_d = '{5'd1, 5'd3};
    bq_s = '{5'd2, 5'd4};
    model(1'b1, merr);
    send_all(1'b1);
    wait_done(0, merr);
    compare_moves("post_rst");

    // Random batches against the reference model.
    for (int b = 0; b < 40; b++) begin
      int n;
      logic [REG_W-1:0] d, s;
      n = $urandom_range(1, MAX_COPIES);
      bq_d.delete();
      bq_s.delete();
      for (int i = 0; i < n; i++) begin
        d = REG_W'($urandom_range(0, 9));
        s = REG_W'($urandom_range(0, 9));
        if ($urandom_range(0, 15) == 0) d = TMP_REG;
        if ($urandom_range(0, 15) == 0) s = TMP_REG;
        bq_d.push_back(d);
        bq_s.push_back(s);
      end
      model(1'b1, merr);
      send_all(1'b1);
      wait_done(2, merr);
      compare_moves("rand");
      semantic_check();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
